// File: rtl/key_bcd_counter.sv
// key_bcd_counter
//
// Four-digit packed-BCD up/down counter driven by one-cycle key event flags.
// Clear has priority; simultaneous increment and decrement cancel. The count,
// an update strobe and a wrap strobe are all registered (one cycle latency).
//
// Build option:
//   KEY_BCD_COUNTER_SAT_EN  defined   -> count saturates at MAX_VALUE / 0000,
//                                        data_valid still pulses, wrap_flag stays 0
//                           undefined -> count wraps MAX_VALUE <-> 0000 with wrap_flag
//
// Parameters:
//   INIT_VALUE  packed-BCD value loaded at reset and on clear
//   MAX_VALUE   packed-BCD upper bound (INIT_VALUE <= MAX_VALUE)
//
// Ports:
//   sys_clk       system clock, rising edge
//   sys_rst_n     asynchronous reset, active low
//   key_inc_flag  one-cycle request: +1
//   key_dec_flag  one-cycle request: -1
//   key_clr_flag  one-cycle request: load INIT_VALUE
//   bcd_data      packed BCD count, [15:12] thousands .. [3:0] units
//   data_valid    one-cycle strobe when bcd_data takes a new value
//   wrap_flag     one-cycle strobe, with data_valid, when the count wrapped

module key_bcd_counter #(
    parameter logic [15:0] INIT_VALUE = 16'h0000,
    parameter logic [15:0] MAX_VALUE  = 16'h9999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_inc_flag,
    input  logic        key_dec_flag,
    input  logic        key_clr_flag,
    output logic [15:0] bcd_data,
    output logic        data_valid,
    output logic        wrap_flag
);

    logic [15:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        wrap_q, wrap_d;

    // Ripple +1 through the nibbles, units first.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple -1 through the nibbles, units first.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (key_clr_flag) begin
            bcd_d   = INIT_VALUE;
            valid_d = 1'b1;
        end else if (key_inc_flag && key_dec_flag) begin
            // Conflicting requests cancel: hold, no strobe.
            bcd_d = bcd_q;
        end else if (key_inc_flag) begin
            valid_d = 1'b1;
            if (bcd_q == MAX_VALUE) begin
`ifdef KEY_BCD_COUNTER_SAT_EN
                bcd_d  = MAX_VALUE;
`else
                bcd_d  = 16'h0000;
                wrap_d = 1'b1;
`endif
            end else begin
                bcd_d = bcd_inc(bcd_q);
            end
        end else if (key_dec_flag) begin
            valid_d = 1'b1;
            if (bcd_q == 16'h0000) begin
`ifdef KEY_BCD_COUNTER_SAT_EN
                bcd_d  = 16'h0000;
`else
                bcd_d  = MAX_VALUE;
                wrap_d = 1'b1;
`endif
            end else begin
                bcd_d = bcd_dec(bcd_q);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bcd_q   <= INIT_VALUE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bcd_data   = bcd_q;
    assign data_valid = valid_q;
    assign wrap_flag  = wrap_q;

endmodule

// File: tb/tb_key_bcd_counter.sv
// tb_key_bcd_counter
//
// Directed bench for key_bcd_counter. Three instances:
//   dut 0: defaults (INIT 0000, MAX 9999)
//   dut 1: MAX_VALUE = 0059
//   dut 2: INIT_VALUE = 9999
// Expected values for the wrap/saturate cases follow KEY_BCD_COUNTER_SAT_EN.

module tb_key_bcd_counter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        inc   [3];
    logic        dec   [3];
    logic        clr   [3];
    logic [15:0] bcd   [3];
    logic        valid [3];
    logic        wrap  [3];

    int n_checks = 0;
    int n_fail   = 0;

    key_bcd_counter u_dut0 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_inc_flag(inc[0]),
        .key_dec_flag(dec[0]),
        .key_clr_flag(clr[0]),
        .bcd_data    (bcd[0]),
        .data_valid  (valid[0]),
        .wrap_flag   (wrap[0])
    );

    key_bcd_counter #(
        .MAX_VALUE(16'h0059)
    ) u_dut1 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_inc_flag(inc[1]),
        .key_dec_flag(dec[1]),
        .key_clr_flag(clr[1]),
        .bcd_data    (bcd[1]),
        .data_valid  (valid[1]),
        .wrap_flag   (wrap[1])
    );

    key_bcd_counter #(
        .INIT_VALUE(16'h9999)
    ) u_dut2 (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_inc_flag(inc[2]),
        .key_dec_flag(dec[2]),
        .key_clr_flag(clr[2]),
        .bcd_data    (bcd[2]),
        .data_valid  (valid[2]),
        .wrap_flag   (wrap[2])
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic has_bad_nibble(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Drive flags for one edge on dut d, then check the registered outputs.
    task automatic step(input int d, input logic i, input logic de, input logic c,
                        input logic [15:0] eb, input logic ev, input logic ew,
                        input string tag);
        inc[d] = i;
        dec[d] = de;
        clr[d] = c;
        @(posedge sys_clk);
        #1;
        inc[d] = 1'b0;
        dec[d] = 1'b0;
        clr[d] = 1'b0;
        check_eq({tag, "_bcd"}, bcd[d], eb);
        check_eq({tag, "_valid"}, {15'b0, valid[d]}, {15'b0, ev});
        check_eq({tag, "_wrap"}, {15'b0, wrap[d]}, {15'b0, ew});
    endtask

    // No nibble may ever leave 0-9 on any instance.
    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            check_eq("nonbcd", {15'b0, has_bad_nibble(bcd[k])}, 16'h0000);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            inc[k] = 1'b0;
            dec[k] = 1'b0;
            clr[k] = 1'b0;
        end
        sys_rst_n = 1'b0;
        #12;
        check_eq("rst_bcd0", bcd[0], 16'h0000);
        check_eq("rst_valid0", {15'b0, valid[0]}, 16'h0000);
        check_eq("rst_wrap0", {15'b0, wrap[0]}, 16'h0000);
        check_eq("rst_bcd1", bcd[1], 16'h0000);
        check_eq("rst_bcd2", bcd[2], 16'h9999);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // Twelve spaced pulses: strobe for exactly one cycle each.
        for (int k = 1; k <= 12; k++) begin
            step(0, 1'b1, 1'b0, 1'b0, to_bcd(k), 1'b1, 1'b0, "inc12");
            step(0, 1'b0, 1'b0, 1'b0, to_bcd(k), 1'b0, 1'b0, "idle12");
        end
        check_eq("after12", bcd[0], 16'h0012);

        // Back-to-back pulses up to 0099.
        for (int k = 13; k <= 99; k++) begin
            step(0, 1'b1, 1'b0, 1'b0, to_bcd(k), 1'b1, 1'b0, "incb2b");
        end
        step(0, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, "inc_0099");
        step(0, 1'b0, 1'b1, 1'b0, 16'h0099, 1'b1, 1'b0, "dec_0100");
        step(0, 1'b1, 1'b1, 1'b0, 16'h0099, 1'b0, 1'b0, "inc_dec");
        step(0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "clr_inc");
        step(0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "clr_at_init");
        step(0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "idle");

`ifdef KEY_BCD_COUNTER_SAT_EN
        step(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "sat_dec_0000");
        step(0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, "sat_inc_0000");
        step(0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "sat_dec_0001");
`else
        step(0, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b1, "wrap_dec_0000");
        step(0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "wrap_inc_9999");
        step(0, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b1, "wrap_dec_again");
        step(0, 1'b0, 1'b1, 1'b0, 16'h9998, 1'b1, 1'b0, "dec_9999");
        step(0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "clr_9998");
`endif

        // MAX_VALUE = 0059 instance.
        for (int k = 1; k <= 59; k++) begin
            step(1, 1'b1, 1'b0, 1'b0, to_bcd(k), 1'b1, 1'b0, "m59_inc");
        end
`ifdef KEY_BCD_COUNTER_SAT_EN
        step(1, 1'b1, 1'b0, 1'b0, 16'h0059, 1'b1, 1'b0, "m59_sat_inc");
        step(1, 1'b0, 1'b1, 1'b0, 16'h0058, 1'b1, 1'b0, "m59_dec");
`else
        step(1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "m59_wrap_inc");
        step(1, 1'b0, 1'b1, 1'b0, 16'h0059, 1'b1, 1'b1, "m59_wrap_dec");
`endif

        // INIT_VALUE = 9999 instance: starts at the top.
`ifdef KEY_BCD_COUNTER_SAT_EN
        step(2, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0, "i9999_sat_inc");
        step(2, 1'b0, 1'b1, 1'b0, 16'h9998, 1'b1, 1'b0, "i9999_dec");
`else
        step(2, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "i9999_wrap_inc");
        step(2, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b1, "i9999_wrap_dec");
`endif
        step(2, 1'b0, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, "i9999_clr");

        // Asynchronous reset mid-cycle with an increment pending.
        step(0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "pre_rst_clr");
        step(0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, "pre_rst_inc");
        inc[0] = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_eq("arst_bcd", bcd[0], 16'h0000);
        check_eq("arst_valid", {15'b0, valid[0]}, 16'h0000);
        check_eq("arst_wrap", {15'b0, wrap[0]}, 16'h0000);
        @(posedge sys_clk);
        #1;
        inc[0] = 1'b0;
        sys_rst_n = 1'b1;
        check_eq("arst_hold_bcd", bcd[0], 16'h0000);
        @(posedge sys_clk);
        #1;
        check_eq("arst_lost_bcd", bcd[0], 16'h0000);
        check_eq("arst_lost_valid", {15'b0, valid[0]}, 16'h0000);
        check_eq("arst_bcd2", bcd[2], 16'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
